// File: rtl/key_debounce_multi_if.sv
// Key-pin and conditioned-event bundle for key_debounce_multi.
// The board side (master) drives raw pins; the conditioner (slave) returns clean levels and pulses.
interface key_debounce_multi_if #(
    parameter int CH = 4
);
    logic [CH-1:0] key_in;
    logic [CH-1:0] key_level;
    logic [CH-1:0] key_press;
    logic [CH-1:0] key_release;
    logic [CH-1:0] key_long;
    logic [CH-1:0] key_repeat;
    logic [CH-1:0] key_fire;

    modport master (
        output key_in,
        input  key_level,
        input  key_press,
        input  key_release,
        input  key_long,
        input  key_repeat,
        input  key_fire
    );

    modport slave (
        input  key_in,
        output key_level,
        output key_press,
        output key_release,
        output key_long,
        output key_repeat,
        output key_fire
    );
endinterface

// File: rtl/key_debounce_multi.sv
// Multi-channel key conditioner: 2-flop sync, tick-driven hysteretic integrator,
// then press/release/long-press/auto-repeat pulse generation per channel.
module key_debounce_multi #(
    parameter int CH         = 4,
    parameter int TICK_DIV   = 50000,
    parameter int DEB_TICKS  = 20,
    parameter int LONG_TICKS = 1000,
    parameter int REP_TICKS  = 200,
    parameter int REPEAT_EN  = 1,
    parameter int ACTIVE_LOW = 1
) (
    input logic                clk,
    input logic                rst,
    key_debounce_multi_if.slave kif
);

    localparam int CW = $clog2(TICK_DIV);
    localparam int IW = $clog2(DEB_TICKS + 1);
    localparam int HW = $clog2(LONG_TICKS + 1);

    localparam logic [CW-1:0] DIV_LAST  = CW'(TICK_DIV - 1);
    localparam logic [IW-1:0] DEB_MAX   = IW'(DEB_TICKS);
    localparam logic [HW-1:0] HC_LONG   = HW'(LONG_TICKS);
    localparam logic [HW-1:0] HC_PRE    = HW'(LONG_TICKS - 1);
    localparam logic [HW-1:0] HC_RELOAD = HW'(LONG_TICKS - REP_TICKS);
    localparam logic [CH-1:0] IDLE_PIN  = (ACTIVE_LOW != 0) ? {CH{1'b1}} : {CH{1'b0}};

    logic [CW-1:0] div_q, div_d;
    logic          tick;

    logic [CH-1:0] sync1_q, sync1_d;
    logic [CH-1:0] sync2_q, sync2_d;
    logic [CH-1:0] raw_pressed;

    logic [IW-1:0] integ_q [CH];
    logic [IW-1:0] integ_d [CH];
    logic [HW-1:0] hc_q    [CH];
    logic [HW-1:0] hc_d    [CH];

    logic [CH-1:0] level_q, level_d;
    logic [CH-1:0] press_q, press_d;
    logic [CH-1:0] release_q, release_d;
    logic [CH-1:0] long_q, long_d;
    logic [CH-1:0] repeat_q, repeat_d;
    logic [CH-1:0] long_seen_q, long_seen_d;

    always_comb begin
        tick    = (div_q == DIV_LAST);
        div_d   = tick ? '0 : div_q + 1'b1;
        sync1_d = kif.key_in;
        sync2_d = sync1_q;
    end

    assign raw_pressed = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

    // Levels only flip when the integrator reaches a rail; hc restarts on every press edge.
    always_comb begin
        level_d     = level_q;
        long_seen_d = long_seen_q;
        long_d      = '0;
        repeat_d    = '0;
        for (int i = 0; i < CH; i++) begin
            integ_d[i] = integ_q[i];
            hc_d[i]    = hc_q[i];
            if (tick) begin
                if (raw_pressed[i] && (integ_q[i] != DEB_MAX)) begin
                    integ_d[i] = integ_q[i] + 1'b1;
                end else if (!raw_pressed[i] && (integ_q[i] != '0)) begin
                    integ_d[i] = integ_q[i] - 1'b1;
                end
                if (integ_d[i] == DEB_MAX) begin
                    level_d[i] = 1'b1;
                end else if (integ_d[i] == '0) begin
                    level_d[i] = 1'b0;
                end
            end
            if (!level_d[i] || !level_q[i]) begin
                hc_d[i]        = '0;
                long_seen_d[i] = 1'b0;
            end else if (tick && (hc_q[i] != HC_LONG)) begin
                // hc only sits at HC_LONG when saturated with repeat disabled
                if (hc_q[i] == HC_PRE) begin
                    if (!long_seen_q[i]) begin
                        long_d[i]      = 1'b1;
                        long_seen_d[i] = 1'b1;
                    end else begin
                        repeat_d[i] = 1'b1;
                    end
                    hc_d[i] = (REPEAT_EN != 0) ? HC_RELOAD : HC_LONG;
                end else begin
                    hc_d[i] = hc_q[i] + 1'b1;
                end
            end
        end
    end

    assign press_d   = level_d & ~level_q;
    assign release_d = ~level_d & level_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q       <= '0;
            sync1_q     <= IDLE_PIN;
            sync2_q     <= IDLE_PIN;
            level_q     <= '0;
            press_q     <= '0;
            release_q   <= '0;
            long_q      <= '0;
            repeat_q    <= '0;
            long_seen_q <= '0;
            for (int i = 0; i < CH; i++) begin
                integ_q[i] <= '0;
                hc_q[i]    <= '0;
            end
        end else begin
            div_q       <= div_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            repeat_q    <= repeat_d;
            long_seen_q <= long_seen_d;
            for (int i = 0; i < CH; i++) begin
                integ_q[i] <= integ_d[i];
                hc_q[i]    <= hc_d[i];
            end
        end
    end

    assign kif.key_level   = level_q;
    assign kif.key_press   = press_q;
    assign kif.key_release = release_q;
    assign kif.key_long    = long_q;
    assign kif.key_repeat  = repeat_q;
    assign kif.key_fire    = press_q | repeat_q;

endmodule

// File: tb/tb_key_debounce_multi.sv
// Scoreboard bench for key_debounce_multi: stimulus queues expected pulses by tick number,
// a negedge monitor pops and compares every pulse either DUT produces.
module tb_key_debounce_multi;

    localparam int CH       = 2;
    localparam int TICK_DIV = 4;
    localparam int KPRESS   = 0;
    localparam int KREL     = 1;
    localparam int KLONG    = 2;
    localparam int KREP     = 3;

    typedef struct {
        int dut;
        int ch;
        int kind;
        int tick;
    } exp_t;

    exp_t expQ[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc;
    int   testsRun    = 0;
    int   testsFailed = 0;
    int   t;

    key_debounce_multi_if #(.CH(CH)) kif0 ();
    key_debounce_multi_if #(.CH(CH)) kif1 ();

    key_debounce_multi #(
        .CH(CH), .TICK_DIV(TICK_DIV), .DEB_TICKS(3), .LONG_TICKS(10),
        .REP_TICKS(4), .REPEAT_EN(1), .ACTIVE_LOW(1)
    ) u_dut0 (
        .clk(clk),
        .rst(rst),
        .kif(kif0)
    );

    key_debounce_multi #(
        .CH(CH), .TICK_DIV(TICK_DIV), .DEB_TICKS(3), .LONG_TICKS(10),
        .REP_TICKS(4), .REPEAT_EN(0), .ACTIVE_LOW(1)
    ) u_dut1 (
        .clk(clk),
        .rst(rst),
        .kif(kif1)
    );

    always #5 clk = ~clk;

    // Posedges since reset release; tick edges are the ones where cyc is a multiple of TICK_DIV.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic logic [CH-1:0] pulseOf(input int d, input int k);
        logic [CH-1:0] p;
        p = '0;
        if (d == 0) begin
            case (k)
                KPRESS:  p = kif0.key_press;
                KREL:    p = kif0.key_release;
                KLONG:   p = kif0.key_long;
                default: p = kif0.key_repeat;
            endcase
        end else begin
            case (k)
                KPRESS:  p = kif1.key_press;
                KREL:    p = kif1.key_release;
                KLONG:   p = kif1.key_long;
                default: p = kif1.key_repeat;
            endcase
        end
        return p;
    endfunction

    function automatic string kindName(input int k);
        case (k)
            KPRESS:  return "press";
            KREL:    return "release";
            KLONG:   return "long";
            default: return "repeat";
        endcase
    endfunction

    task automatic pushExp(input int d, input int c, input int k, input int tk);
        exp_t e;
        e.dut  = d;
        e.ch   = c;
        e.kind = k;
        e.tick = tk;
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int d, input int c, input logic v);
        if (d == 0) kif0.key_in[c] = v;
        else        kif1.key_in[c] = v;
    endtask

    task automatic alignTick();
        @(negedge clk);
        while (cyc % TICK_DIV != 0) @(negedge clk);
    endtask

    task automatic waitTicks(input int n);
        repeat (n * TICK_DIV) @(negedge clk);
    endtask

    // Every pulse on any channel of either DUT must match the head of the queue exactly.
    exp_t          mon_e;
    logic [CH-1:0] mon_p;
    logic [CH-1:0] mon_fire;
    logic [CH-1:0] mon_fireExp;
    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < CH; c++) begin
                    for (int k = 0; k < 4; k++) begin
                        mon_p = pulseOf(d, k);
                        if (mon_p[c]) begin
                            testsRun++;
                            if (expQ.size() == 0) begin
                                testsFailed++;
                                $display("[TB] FAIL unexpectedPulse: got dut%0d ch%0d %s at cyc %0d, expected no pulse",
                                         d, c, kindName(k), cyc);
                            end else begin
                                mon_e = expQ.pop_front();
                                if (mon_e.dut != d || mon_e.ch != c || mon_e.kind != k ||
                                    mon_e.tick * TICK_DIV != cyc) begin
                                    testsFailed++;
                                    $display("[TB] FAIL pulseMatch: got dut%0d ch%0d %s at cyc %0d, expected dut%0d ch%0d %s at cyc %0d",
                                             d, c, kindName(k), cyc, mon_e.dut, mon_e.ch,
                                             kindName(mon_e.kind), mon_e.tick * TICK_DIV);
                                end
                            end
                        end
                    end
                end
                mon_fire    = (d == 0) ? kif0.key_fire : kif1.key_fire;
                mon_fireExp = pulseOf(d, KPRESS) | pulseOf(d, KREP);
                if ((mon_fire | mon_fireExp) != '0) begin
                    testsRun++;
                    if (mon_fire !== mon_fireExp) begin
                        testsFailed++;
                        $display("[TB] FAIL fireDut%0d: got %b expected %b", d, mon_fire, mon_fireExp);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        testsFailed++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        kif0.key_in = '1;
        kif1.key_in = '1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rstLevel0",   kif0.key_level,   0);
        checkOutput("rstPress0",   kif0.key_press,   0);
        checkOutput("rstRelease0", kif0.key_release, 0);
        checkOutput("rstLong0",    kif0.key_long,    0);
        checkOutput("rstRepeat0",  kif0.key_repeat,  0);
        checkOutput("rstFire0",    kif0.key_fire,    0);
        checkOutput("rstLevel1",   kif1.key_level,   0);
        rst = 1'b0;

        repeat (200) @(negedge clk);
        checkOutput("idleLevel0", kif0.key_level, 0);
        checkOutput("idleLevel1", kif1.key_level, 0);

        // single clean press and release on ch0
        alignTick();
        t = cyc / TICK_DIV;
        applyStimulus(0, 0, 1'b0);
        pushExp(0, 0, KPRESS, t + 3);
        pushExp(0, 0, KREL,   t + 6);
        waitTicks(2);
        checkOutput("levelBeforePress", kif0.key_level, 2'b00);
        waitTicks(1);
        checkOutput("levelAfterPress", kif0.key_level, 2'b01);
        applyStimulus(0, 0, 1'b1);
        waitTicks(2);
        checkOutput("levelMidRelease", kif0.key_level, 2'b01);
        waitTicks(1);
        checkOutput("levelAfterRelease", kif0.key_level, 2'b00);
        waitTicks(3);
        #1 checkOutput("drainSingle", expQ.size(), 0);

        // bounce, settle, 1-tick glitch, then 30-tick hold with long and repeats
        alignTick();
        t = cyc / TICK_DIV;
        pushExp(0, 0, KPRESS, t + 14);
        pushExp(0, 0, KLONG,  t + 24);
        for (int k = 1; k <= 5; k++) pushExp(0, 0, KREP, t + 24 + 4 * k);
        pushExp(0, 0, KREL, t + 47);
        for (int j = 0; j < 14; j++) begin
            applyStimulus(0, 0, logic'(j % 2));
            repeat (3) @(negedge clk);
        end
        applyStimulus(0, 0, 1'b0);
        checkOutput("levelDuringBounce", kif0.key_level, 2'b00);
        repeat (14) @(negedge clk);
        checkOutput("levelAfterSettle", kif0.key_level, 2'b01);
        applyStimulus(0, 0, 1'b1);
        repeat (4) @(negedge clk);
        applyStimulus(0, 0, 1'b0);
        waitTicks(2);
        checkOutput("levelAfterGlitch", kif0.key_level, 2'b01);
        waitTicks(27);
        applyStimulus(0, 0, 1'b1);
        waitTicks(3);
        checkOutput("levelAfterHold", kif0.key_level, 2'b00);
        waitTicks(5);
        #1 checkOutput("drainHold", expQ.size(), 0);

        // repeat disabled: one long pulse only
        alignTick();
        t = cyc / TICK_DIV;
        applyStimulus(1, 0, 1'b0);
        pushExp(1, 0, KPRESS, t + 3);
        pushExp(1, 0, KLONG,  t + 13);
        pushExp(1, 0, KREL,   t + 36);
        waitTicks(33);
        checkOutput("noRepLevel", kif1.key_level, 2'b01);
        applyStimulus(1, 0, 1'b1);
        waitTicks(8);
        #1 checkOutput("drainNoRepeat", expQ.size(), 0);

        // simultaneous press; ch1 released before reaching long-press
        alignTick();
        t = cyc / TICK_DIV;
        applyStimulus(0, 0, 1'b0);
        applyStimulus(0, 1, 1'b0);
        pushExp(0, 0, KPRESS, t + 3);
        pushExp(0, 1, KPRESS, t + 3);
        pushExp(0, 1, KREL,   t + 12);
        pushExp(0, 0, KLONG,  t + 13);
        pushExp(0, 0, KREL,   t + 17);
        waitTicks(3);
        checkOutput("dualLevel", kif0.key_level, 2'b11);
        waitTicks(6);
        applyStimulus(0, 1, 1'b1);
        waitTicks(5);
        checkOutput("dualLevelCh1Gone", kif0.key_level, 2'b01);
        applyStimulus(0, 0, 1'b1);
        waitTicks(8);
        #1 checkOutput("drainDual", expQ.size(), 0);

        // asynchronous reset in the middle of a hold
        alignTick();
        t = cyc / TICK_DIV;
        applyStimulus(0, 0, 1'b0);
        pushExp(0, 0, KPRESS, t + 3);
        waitTicks(5);
        checkOutput("preResetLevel", kif0.key_level, 2'b01);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("asyncRstOutputs0",
                    {kif0.key_level, kif0.key_press, kif0.key_release,
                     kif0.key_long, kif0.key_repeat, kif0.key_fire}, 0);
        checkOutput("asyncRstOutputs1",
                    {kif1.key_level, kif1.key_press, kif1.key_release,
                     kif1.key_long, kif1.key_repeat, kif1.key_fire}, 0);
        applyStimulus(0, 0, 1'b1);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        waitTicks(10);
        checkOutput("postResetLevel", kif0.key_level, 2'b00);
        #1 checkOutput("drainReset", expQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
